// File: rtl/pcie_dll_tx.sv
// ============================================================================
// Module   : pcie_dll_tx
// Purpose  : PCIe DLL transmit stage: sequence numbering, LCRC, replay buffer,
//            ACK/NAK retirement and replay. Optional timer replay is enabled by
//            defining PCIE_DLL_REPLAY_TIMER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pcie_dll_tx #(
  parameter int RB_DEPTH       = 16,
  parameter int REPLAY_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tlp_valid_i,
  input  logic [223:0] tlp_i,
  output logic         tlp_ready_o,
  output logic         dll_valid_o,
  output logic [271:0] dll_o,
  input  logic         dll_ready_i,
  input  logic         ack_valid_i,
  input  logic         ack_nak_i,
  input  logic [11:0]  ack_seq_i,
  output logic         dll_err_o,
  output logic         retrain_req_o
);

  localparam int AW = $clog2(RB_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] C_POLY = 32'h04C11DB7;

  typedef enum logic [0:0] {SEND = 1'b0, REPLAY = 1'b1} state_t;

  function automatic logic [31:0] f_lcrc(input logic [239:0] m);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 239; i >= 0; i--) begin
      fb = c[31] ^ m[i];
      c  = {c[30:0], 1'b0} ^ (fb ? C_POLY : 32'h0);
    end
    return ~c;
  endfunction

  state_t        r_state;
  logic          r_init;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_rb_count;
  logic [CW-1:0] r_rp_done;
  logic [11:0]   r_next_seq;
  logic [11:0]   r_ackd_seq;
  logic [1:0]    r_replay_num;
  logic          r_replay_pending;
  logic [271:0]  r_rb_mem [RB_DEPTH];

  logic [11:0]   w_d;
  logic          w_ack_ok;
  logic          w_err;
  logic          w_nak;
  logic          w_progress;
  logic [CW-1:0] w_purge;
  logic [CW-1:0] w_cnt_p;
  logic [CW-1:0] w_done_p;
  logic [CW-1:0] w_left_p;
  logic [AW-1:0] w_head_n;
  logic [AW-1:0] w_rd_ptr;
  logic          w_slot_free;
  logic          w_accept;
  logic          w_entry;
  logic          w_tmo;
  logic [239:0]  w_frame;
  logic [271:0]  w_word;

  assign w_d         = ack_seq_i - r_ackd_seq;
  assign w_ack_ok    = ack_valid_i && (w_d <= 12'(r_rb_count));
  assign w_err       = ack_valid_i && !w_ack_ok;
  assign w_nak       = w_ack_ok && ack_nak_i;
  assign w_progress  = w_ack_ok && (w_d != 12'd0);
  assign w_purge     = w_ack_ok ? w_d[CW-1:0] : '0;
  assign w_cnt_p     = r_rb_count - w_purge;
  assign w_head_n    = r_head + w_purge[AW-1:0];
  // Acked entries that were already resent are gone; the rest shift to head.
  assign w_done_p    = (w_purge >= r_rp_done) ? '0 : (r_rp_done - w_purge);
  assign w_left_p    = w_cnt_p - w_done_p;
  assign w_rd_ptr    = w_head_n + w_done_p[AW-1:0];
  assign w_slot_free = !dll_valid_o || dll_ready_i;
  assign w_frame     = {4'b0000, r_next_seq, tlp_i};
  assign w_word      = {w_frame, f_lcrc(w_frame)};

  assign tlp_ready_o = r_init && (r_state == SEND) && (r_rb_count < CW'(RB_DEPTH))
                       && w_slot_free && !r_replay_pending;
  assign w_accept    = tlp_valid_i && tlp_ready_o;
  assign w_entry     = (r_state == SEND) && r_replay_pending && w_slot_free
                       && (w_cnt_p != '0);

`ifdef PCIE_DLL_REPLAY_TIMER_EN
  localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
  logic [TW-1:0] r_timer;

  assign w_tmo = (r_state == SEND) && (r_rb_count != '0) && !w_progress
                 && (r_timer == TW'(REPLAY_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_tmo || w_progress || w_entry || (r_state != SEND) || (r_rb_count == '0)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end
`else
  // No timer in this build; the term folds to a constant zero.
  assign w_tmo = (REPLAY_TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rb_mem[r_tail] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= SEND;
      r_init           <= 1'b0;
      r_head           <= '0;
      r_tail           <= '0;
      r_rb_count       <= '0;
      r_rp_done        <= '0;
      r_next_seq       <= 12'd0;
      r_ackd_seq       <= 12'hFFF;
      r_replay_num     <= 2'd0;
      r_replay_pending <= 1'b0;
      dll_valid_o      <= 1'b0;
      dll_o            <= '0;
      dll_err_o        <= 1'b0;
      retrain_req_o    <= 1'b0;
    end else begin
      r_init        <= 1'b1;
      dll_err_o     <= w_err;
      retrain_req_o <= 1'b0;
      r_head        <= w_head_n;
      r_rb_count    <= w_cnt_p + CW'(w_accept);
      if (w_ack_ok) begin
        r_ackd_seq <= ack_seq_i;
      end
      if (w_progress) begin
        r_replay_num <= 2'd0;
      end
      if (w_slot_free) begin
        dll_valid_o <= 1'b0;
      end
      if (w_accept) begin
        r_tail      <= r_tail + AW'(1);
        r_next_seq  <= r_next_seq + 12'd1;
        dll_valid_o <= 1'b1;
        dll_o       <= w_word;
      end
      case (r_state)
        SEND: begin
          if (w_entry) begin
            r_state          <= REPLAY;
            r_replay_pending <= 1'b0;
            r_rp_done        <= '0;
            r_replay_num     <= (w_progress ? 2'd0 : r_replay_num) + 2'd1;
            retrain_req_o    <= !w_progress && (r_replay_num == 2'd3);
          end else if (r_replay_pending && (w_cnt_p == '0)) begin
            r_replay_pending <= w_nak;
          end else begin
            r_replay_pending <= r_replay_pending | w_nak | w_tmo;
          end
        end
        REPLAY: begin
          r_replay_pending <= r_replay_pending | w_nak;
          if (w_slot_free) begin
            if (w_left_p == '0) begin
              r_state   <= SEND;
              r_rp_done <= '0;
            end else begin
              dll_valid_o <= 1'b1;
              dll_o       <= r_rb_mem[w_rd_ptr];
              r_rp_done   <= w_done_p + CW'(1);
              if (w_left_p == CW'(1)) begin
                r_state <= SEND;
              end
            end
          end else begin
            r_rp_done <= w_done_p;
          end
        end
        default: r_state <= SEND;
      endcase
    end
  end

endmodule

`default_nettype wire
